embed_seq_ctrl: RTL and testbench

//  Sequencer for watermark embedding: out = LL1 + alpha*LL2 per DWT coefficient pair.

---
 rtl/embed_pkg.sv | 34 +++
 rtl/serial_mult.sv | 58 +++++
 rtl/embed_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_embed_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/embed_pkg.sv
// ============================================================================
// embed_pkg : shared state encoding, default sizes and width helper for the
//             watermark-embedding sequencer.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package embed_pkg;

  localparam int c_default_n         = 16;
  localparam int c_default_frame_len = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MULT  = 3'd2,
    S_ADD   = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // ceil(log2(v)), never less than 1 so single-entry counters still get a bit
  function automatic int clog2_min1(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mult.sv
// ============================================================================
// serial_mult : N-cycle unsigned shift-add multiplier, one multiplier bit per
//               cycle LSB first; p is final on the cycle busy falls.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module serial_mult
  import embed_pkg::*;
#(
  parameter int N = c_default_n
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic [2*N-1:0]   p
);

  localparam int                c_cnt_w    = clog2_min1(N);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);

  logic [2*N-1:0]     r_mcand;
  logic [N-1:0]       r_mplier;
  logic [2*N-1:0]     r_p;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (load) begin
      r_mcand  <= {{N{1'b0}}, a};
      r_mplier <= b;
      r_p      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) r_p <= r_p + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == c_cnt_last) r_busy <= 1'b0;
      else                     r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign busy = r_busy;
  assign p    = r_p;

endmodule

`default_nettype wire

// File: rtl/embed_seq_ctrl.sv
// ============================================================================
// embed_seq_ctrl : streams FRAME_LEN (ll1, ll2) pairs through one serial
//                  multiplier producing ll1 + alpha*ll2, then pulses done.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module embed_seq_ctrl
  import embed_pkg::*;
#(
  parameter  int N         = c_default_n,
  parameter  int FRAME_LEN = c_default_frame_len,
  localparam int c_idx_w   = clog2_min1(FRAME_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [N-1:0]       alpha,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       ll1,
  input  logic [N-1:0]       ll2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N-1:0]     out_data,
  output logic [c_idx_w-1:0] coef_idx,
  output logic               busy,
  output logic               done
);

  localparam int                 c_bit_w    = clog2_min1(N);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(FRAME_LEN - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(N - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic [N-1:0]       r_alpha;
  logic [N-1:0]       r_ll1;
  logic [c_bit_w-1:0] r_bit_cnt;
  logic [c_idx_w-1:0] r_coef_idx;
  logic [2*N-1:0]     r_out_data;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;
  logic               w_mult_busy;
  logic [2*N-1:0]     w_mult_p;

  serial_mult #(.N(N)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .a     (r_alpha),
    .b     (ll2),
    .busy  (w_mult_busy),
    .p     (w_mult_p)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: if (in_valid) begin
                 w_state_nxt = S_MULT;
                 w_load      = 1'b1;
               end
      S_MULT:  if (r_bit_cnt == c_bit_last) w_state_nxt = S_ADD;
      S_ADD:   if (!w_mult_busy) w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = (r_coef_idx == c_idx_last) ? S_DONE : S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // abort overrides every transition, including a simultaneous start
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_FETCH);
      r_out_valid <= (w_state_nxt == S_OUT);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alpha    <= '0;
      r_ll1      <= '0;
      r_bit_cnt  <= '0;
      r_coef_idx <= '0;
      r_out_data <= '0;
    end else begin
      if (r_state == S_IDLE && start && !abort) r_alpha <= alpha;

      if (w_load) begin
        r_ll1     <= ll1;
        r_bit_cnt <= '0;
      end else if (r_state == S_MULT) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (abort || (r_state == S_IDLE && start))
        r_coef_idx <= '0;
      else if (r_state == S_OUT && out_ready && r_coef_idx != c_idx_last)
        r_coef_idx <= r_coef_idx + 1'b1;

      if (r_state == S_ADD && !w_mult_busy && !abort)
        r_out_data <= w_mult_p + {{N{1'b0}}, r_ll1};
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign coef_idx  = r_coef_idx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_embed_seq_ctrl.sv
// ============================================================================
// tb_embed_seq_ctrl : directed and randomized checks of embed_seq_ctrl
//                     against an arithmetic reference ll1 + alpha*ll2.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_embed_seq_ctrl;

  localparam int N  = 16;
  localparam int FL = 4;
  localparam int W  = 2 * N;

  logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] alpha = '0, ll1 = '0, ll2 = '0;
  logic         in_ready, out_valid, busy, done;
  logic [W-1:0] out_data;
  logic [1:0]   coef_idx;

  int total = 0, bad = 0, ticks = 0, done_tick = 0;

  logic [N-1:0] blk_l1 [FL];
  logic [N-1:0] blk_l2 [FL];
  logic [W-1:0] blk_exp[FL];
  int           blk_gap[FL];
  int           blk_stall[FL];

  embed_seq_ctrl #(.N(N), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .alpha(alpha),
    .in_valid(in_valid), .in_ready(in_ready), .ll1(ll1), .ll2(ll2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_idx(coef_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  function automatic logic [W-1:0] ref_out(input logic [N-1:0] a, l1, l2);
    logic [W-1:0] wa, w1, w2;
    wa = W'(a);
    w1 = W'(l1);
    w2 = W'(l2);
    return w1 + wa * w2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [N-1:0] a);
    alpha = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    alpha = N'($urandom);
    chk("start_fetch", {busy, in_ready, coef_idx}, {1'b1, 1'b1, 2'd0});
  endtask

  task automatic accept_pair(input logic [N-1:0] l1, l2, input int gap);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("fetch_wait", {in_ready, out_valid}, 2'b10);
    end
    ll1 = l1;
    ll2 = l2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ll1 = N'($urandom);
    ll2 = N'($urandom);
    chk("accept_ready_drop", in_ready, 1'b0);
  endtask

  task automatic finish_pair(input logic [W-1:0] exp, input int idx, input int stall, input bit last);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < N + 10) begin
      tick();
      lat++;
    end
    chk("latency", lat, N + 1);
    chk("out_data", out_data, exp);
    chk("coef_idx", coef_idx, idx);
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_hold", {out_valid, coef_idx, out_data}, {1'b1, 2'(idx), exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (last) begin
      chk("done_pulse", {done, out_valid, busy}, 3'b101);
      done_tick = ticks;
      tick();
      chk("done_clear", {done, busy, in_ready}, 3'b000);
    end else begin
      chk("next_fetch", {in_ready, done, out_valid, coef_idx}, {3'b100, 2'(idx + 1)});
    end
  endtask

  task automatic run_block(input logic [N-1:0] a);
    do_start(a);
    for (int i = 0; i < FL; i++) begin
      accept_pair(blk_l1[i], blk_l2[i], blk_gap[i]);
      finish_pair(blk_exp[i], i, blk_stall[i], i == FL - 1);
    end
  endtask

  initial begin
    int t0;
    int lat;
    bit seen;
    logic [N-1:0] a_r;

    // reset values, asserted asynchronously before any clock edge
    #2 rst_n = 1'b0;
    #2;
    chk("reset_outs", {in_ready, out_valid, busy, done, coef_idx, out_data}, '0);
    #10 rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_no_start", {busy, in_ready, out_valid, done}, 4'b0000);

    // directed block: alpha=3, no stalls, also start-to-done cycle count
    blk_l1  = '{16'd5, 16'd0, 16'd7, 16'd1};
    blk_l2  = '{16'd2, 16'd9, 16'd0, 16'd1};
    blk_exp = '{32'd11, 32'd27, 32'd7, 32'd4};
    blk_gap = '{0, 0, 0, 0};
    blk_stall = '{0, 0, 0, 0};
    t0 = ticks;
    run_block(16'd3);
    chk("start_to_done", done_tick - t0, FL * (N + 3) + 1);

    // extremes plus input gaps and a long output stall
    blk_l1  = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h1234};
    blk_l2  = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h8001};
    blk_exp = '{32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFE_0001, ref_out(16'hFFFF, 16'h1234, 16'h8001)};
    blk_gap = '{0, 5, 2, 0};
    blk_stall = '{10, 0, 3, 10};
    run_block(16'hFFFF);

    // abort in MULT of the second pair
    do_start(16'd7);
    accept_pair(16'd1, 16'd1, 0);
    finish_pair(32'd8, 0, 0, 1'b0);
    accept_pair(16'd2, 16'd3, 0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {busy, in_ready, out_valid, done, coef_idx}, 6'b0);
    seen = 1'b0;
    repeat (N + 5) begin
      tick();
      if (out_valid !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    chk("abort_quiet", seen, 1'b0);
    alpha = 16'd9;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle", {busy, in_ready}, 2'b00);
    blk_l1  = '{16'd10, 16'd0, 16'd100, 16'hFFFF};
    blk_l2  = '{16'd1, 16'd5, 16'd0, 16'd1};
    blk_exp = '{32'd12, 32'd10, 32'd100, 32'h0001_0001};
    blk_gap = '{1, 0, 0, 0};
    blk_stall = '{0, 1, 0, 0};
    run_block(16'd2);

    // start while busy is ignored; then async reset in OUT
    do_start(16'd5);
    start = 1'b1;
    alpha = 16'd99;
    accept_pair(16'd3, 16'd4, 2);
    start = 1'b0;
    finish_pair(32'd23, 0, 0, 1'b0);
    accept_pair(16'd10, 16'd10, 0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < N + 10) begin
      tick();
      lat++;
    end
    chk("busy_start_ignored", {out_valid, out_data}, {1'b1, 32'd60});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {in_ready, out_valid, busy, done, coef_idx, out_data}, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {busy, in_ready, out_valid}, 3'b000);

    // randomized blocks against the arithmetic reference
    for (int b = 0; b < 200 / FL; b++) begin
      case ($urandom_range(0, 7))
        0:       a_r = '0;
        1:       a_r = '1;
        default: a_r = N'($urandom);
      endcase
      for (int i = 0; i < FL; i++) begin
        blk_l1[i]    = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
        blk_l2[i]    = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
        blk_exp[i]   = ref_out(a_r, blk_l1[i], blk_l2[i]);
        blk_gap[i]   = $urandom_range(0, 3);
        blk_stall[i] = $urandom_range(0, 3);
      end
      run_block(a_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
